data_mem_store_buf: RTL and testbench

//   Posted-write store buffer between the store-data mux and the data memory.
//   - Accepts stores (address, data, byte enables) from the MEM stage in one cycle.
//   - Drains them in order to the data RAM over a req/ack handshake, so memory

---
 rtl/data_mem_store_buf.sv | 177 +++++++++++++++++
 tb/tb_data_mem_store_buf.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_store_buf.sv
// Posted-write store buffer: in-order drain to the data RAM over req/ack, with a load-hit check.
// Optional store-to-load forwarding is built when STORE_BUF_FWD_EN is defined.
module data_mem_store_buf #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            st_valid,
  input  logic [AW-1:0]   st_addr,
  input  logic [DW-1:0]   st_data,
  input  logic [DW/8-1:0] st_be,
  output logic            st_ready,
  input  logic [AW-1:0]   ld_addr,
  input  logic            ld_valid,
  output logic            ld_hit,
  output logic            ld_fwd_valid,
  output logic [DW-1:0]   ld_fwd_data,
  output logic            mem_req,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_ack,
  output logic            buf_empty
);

  localparam int BW = DW / 8;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [AW-1:0]   r_ent_addr [DEPTH];
  logic [DW-1:0]   r_ent_data [DEPTH];
  logic [BW-1:0]   r_ent_be   [DEPTH];
  logic [DEPTH-1:0] r_ent_vld;

  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_wdata;
  logic [BW-1:0]   r_mem_be;

  logic            w_st_ready;
  logic            w_push;
  logic            w_pop;
  logic            w_load;
  logic            w_head_bypass;
  logic [PW-1:0]   w_rptr_next;
  logic [CW-1:0]   w_count_next;
  logic [DEPTH-1:0] w_match;
  logic            w_unused_ld;

  assign w_st_ready   = (r_count != CW'(DEPTH));
  assign w_push       = st_valid && w_st_ready;
  assign w_pop        = (r_state == S_REQ) && mem_ack;
  assign w_rptr_next  = w_pop ? (r_rptr + PW'(1)) : r_rptr;
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

  // With one entry left, a same-cycle push lands exactly where the new head will be.
  assign w_head_bypass = w_push && (r_wptr == w_rptr_next);

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_state_next = S_REQ;
          w_load       = 1'b1;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          if (w_count_next != '0) begin
            w_state_next = S_REQ;
            w_load       = 1'b1;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_ent_vld   <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_rptr  <= w_rptr_next;
      if (w_pop) begin
        r_ent_vld[r_rptr] <= 1'b0;
      end
      if (w_push) begin
        r_ent_vld[r_wptr] <= 1'b1;
        r_wptr            <= r_wptr + PW'(1);
      end
      if (w_load) begin
        if (w_head_bypass) begin
          r_mem_addr  <= st_addr;
          r_mem_wdata <= st_data;
          r_mem_be    <= st_be;
        end else begin
          r_mem_addr  <= r_ent_addr[w_rptr_next];
          r_mem_wdata <= r_ent_data[w_rptr_next];
          r_mem_be    <= r_ent_be[w_rptr_next];
        end
      end
    end
  end

  // Payload storage needs no reset; the valid bits guard every use.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ent_addr[r_wptr] <= st_addr;
      r_ent_data[r_wptr] <= st_data;
      r_ent_be[r_wptr]   <= st_be;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign w_match[gi] = r_ent_vld[gi] && (r_ent_addr[gi][AW-1:2] == ld_addr[AW-1:2]);
    end
  endgenerate

  assign ld_hit      = ld_valid && (|w_match);
  assign w_unused_ld = &{1'b0, ld_addr[1:0]};

`ifdef STORE_BUF_FWD_EN
  logic [PW-1:0] w_fwd_idx;

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    logic [PW-1:0] v_idx;
    v_idx     = '0;
    w_fwd_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      v_idx = r_rptr + PW'(k);
      if (w_match[v_idx]) begin
        w_fwd_idx = v_idx;
      end
    end
  end

  assign ld_fwd_valid = ld_hit && (r_ent_be[w_fwd_idx] == '1);
  assign ld_fwd_data  = ld_fwd_valid ? r_ent_data[w_fwd_idx] : '0;
`else
  assign ld_fwd_valid = 1'b0;
  assign ld_fwd_data  = '0;
`endif

  assign st_ready  = w_st_ready;
  assign mem_req   = (r_state == S_REQ);
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;
  assign buf_empty = (r_count == '0) && !mem_req;

endmodule

// File: tb/tb_data_mem_store_buf.sv
// Directed bench for data_mem_store_buf: queue scoreboard of expected RAM writes,
// popped and compared as each request is acknowledged.
module tb_data_mem_store_buf;

  logic        clk;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic        st_ready;
  logic [31:0] ld_addr;
  logic        ld_valid;
  logic        ld_hit;
  logic        ld_fwd_valid;
  logic [31:0] ld_fwd_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        buf_empty;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
  } wr_t;

  wr_t q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  data_mem_store_buf #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_be(st_be),
    .st_ready(st_ready),
    .ld_addr(ld_addr), .ld_valid(ld_valid), .ld_hit(ld_hit),
    .ld_fwd_valid(ld_fwd_valid), .ld_fwd_data(ld_fwd_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .buf_empty(buf_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_step(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] b, input bit exp_acc);
    wr_t e;
    st_valid = 1'b1; st_addr = a; st_data = d; st_be = b;
    check("st_ready", st_ready, exp_acc);
    if (exp_acc) begin
      e.a = a; e.d = d; e.b = b;
      q.push_back(e);
    end
    $display("store addr=0x%08h data=0x%08h be=0x%h accept_expected=%0d", a, d, b, exp_acc);
    @(negedge clk);
    st_valid = 1'b0;
  endtask

  task automatic ack_check(input string tag);
    wr_t e;
    check({tag, "_req"}, mem_req, 1);
    check({tag, "_sb_nonempty"}, q.size() != 0, 1);
    if (q.size() != 0) begin
      e = q.pop_front();
      check({tag, "_addr"}, mem_addr, e.a);
      check({tag, "_data"}, mem_wdata, e.d);
      check({tag, "_be"}, mem_be, e.b);
    end
    $display("ram write addr=0x%08h data=0x%08h be=0x%h", mem_addr, mem_wdata, mem_be);
    mem_ack = 1'b1;
  endtask

  task automatic push_ack_step(input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] b, input bit exp_acc);
    wr_t e;
    st_valid = 1'b1; st_addr = a; st_data = d; st_be = b;
    check("pa_st_ready", st_ready, exp_acc);
    ack_check("pa");
    if (exp_acc) begin
      e.a = a; e.d = d; e.b = b;
      q.push_back(e);
    end
    $display("store+ack addr=0x%08h data=0x%08h accept_expected=%0d", a, d, exp_acc);
    @(negedge clk);
    st_valid = 1'b0;
    mem_ack  = 1'b0;
  endtask

  task automatic drain(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      ack_check(tag);
      @(negedge clk);
    end
    mem_ack = 1'b0;
  endtask

  task automatic wait_req(input int bound);
    int n = 0;
    while (!mem_req && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("req_wait", mem_req, 1);
  endtask

  initial begin
    rst = 1'b1; mem_ack = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = '0;
    ld_valid = 1'b0; ld_addr = '0;
    @(negedge clk);
    @(negedge clk);
    // Reset state
    check("rst_mem_req", mem_req, 0);
    check("rst_st_ready", st_ready, 1);
    check("rst_buf_empty", buf_empty, 1);
    check("rst_ld_hit", ld_hit, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_fwd_valid", ld_fwd_valid, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single store: latency and payload stability
    push_step(32'h100, 32'hDEADBEEF, 4'hF, 1);
    check("lat_req_early", mem_req, 0);
    check("lat_not_empty", buf_empty, 0);
    @(negedge clk);
    check("lat_req_rise", mem_req, 1);
    check("lat_addr", mem_addr, 32'h100);
    @(negedge clk);
    check("stable_addr", mem_addr, 32'h100);
    check("stable_data", mem_wdata, 32'hDEADBEEF);
    drain(1, "single");
    check("single_req_low", mem_req, 0);
    check("single_empty", buf_empty, 1);

    // Fill, drop the overflow store, then back-to-back drain
    for (int i = 0; i < 4; i++) push_step(32'h1000 + 32'(i * 4), 32'hA0 + 32'(i), 4'hF, 1);
    push_step(32'h2000, 32'hBAD0BAD0, 4'hF, 0);
    check("full_ready", st_ready, 0);
    drain(4, "b2b");
    check("b2b_empty", buf_empty, 1);

    // Full with a simultaneous pop: push still rejected
    for (int i = 0; i < 4; i++) push_step(32'h3000 + 32'(i * 4), 32'hB0 + 32'(i), 4'h5, 1);
    push_ack_step(32'h3100, 32'hBAD1BAD1, 4'hF, 0);
    check("after_pop_ready", st_ready, 1);
    drain(3, "fullpop");
    check("fullpop_empty", buf_empty, 1);

    // Count 2: push and pop together leave count at 2
    push_step(32'h4000, 32'hC0, 4'hF, 1);
    push_step(32'h4004, 32'hC1, 4'hF, 1);
    push_ack_step(32'h4008, 32'hC2, 4'hF, 1);
    push_step(32'h400C, 32'hC3, 4'hF, 1);
    push_step(32'h4010, 32'hC4, 4'hF, 1);
    push_step(32'h4014, 32'hC5, 4'hF, 0);
    drain(4, "cnt2");
    check("cnt2_empty", buf_empty, 1);

    // One entry in flight: push and pop together, new store becomes the head
    push_step(32'h300, 32'h11110000, 4'hF, 1);
    wait_req(4);
    push_ack_step(32'h304, 32'h22220000, 4'hC, 1);
    drain(1, "bypass");
    check("bypass_empty", buf_empty, 1);

    // Load check and forwarding
    push_step(32'h104, 32'h11223344, 4'hF, 1);
    ld_valid = 1'b1; ld_addr = 32'h106; #1;
    check("ld_hit_106", ld_hit, 1);
`ifdef STORE_BUF_FWD_EN
    check("fwd_valid_full", ld_fwd_valid, 1);
    check("fwd_data_full", ld_fwd_data, 32'h11223344);
`else
    check("fwd_valid_off", ld_fwd_valid, 0);
    check("fwd_data_off", ld_fwd_data, 0);
`endif
    ld_addr = 32'h108; #1;
    check("ld_hit_108", ld_hit, 0);
    ld_addr = 32'h104; ld_valid = 1'b0; #1;
    check("ld_hit_novalid", ld_hit, 0);
    @(negedge clk);
    push_step(32'h104, 32'hAAAA5555, 4'h3, 1);
    ld_valid = 1'b1; ld_addr = 32'h104; #1;
    check("ld_hit_partial", ld_hit, 1);
    check("fwd_valid_partial", ld_fwd_valid, 0);
    @(negedge clk);
    push_step(32'h104, 32'hCAFEF00D, 4'hF, 1);
    ld_addr = 32'h105; #1;
    check("ld_hit_young", ld_hit, 1);
`ifdef STORE_BUF_FWD_EN
    check("fwd_valid_young", ld_fwd_valid, 1);
    check("fwd_data_young", ld_fwd_data, 32'hCAFEF00D);
`else
    check("fwd_valid_young_off", ld_fwd_valid, 0);
`endif
    @(negedge clk);
    ld_valid = 1'b0;
    drain(3, "ld");
    ld_valid = 1'b1; ld_addr = 32'h104; #1;
    check("ld_hit_drained", ld_hit, 0);
    @(negedge clk);

    // A store pushed in the same cycle does not count as a hit
    st_valid = 1'b1; st_addr = 32'h200; st_data = 32'h5A5A5A5A; st_be = 4'hF;
    ld_addr = 32'h200; #1;
    check("ld_hit_same_cycle", ld_hit, 0);
    @(negedge clk);
    st_valid = 1'b0;
    begin
      wr_t e;
      e.a = 32'h200; e.d = 32'h5A5A5A5A; e.b = 4'hF;
      q.push_back(e);
    end
    check("ld_hit_next_cycle", ld_hit, 1);
    ld_valid = 1'b0;
    wait_req(4);
    drain(1, "samecyc");

    // Reset mid-drain discards pending entries
    push_step(32'h500, 32'h50, 4'hF, 1);
    push_step(32'h504, 32'h51, 4'hF, 1);
    push_step(32'h508, 32'h52, 4'hF, 1);
    check("pre_rst_req", mem_req, 1);
    rst = 1'b1; #1;
    check("mid_rst_req", mem_req, 0);
    check("mid_rst_empty", buf_empty, 1);
    check("mid_rst_ready", st_ready, 1);
    check("mid_rst_addr", mem_addr, 0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_req", mem_req, 0);
    end
    mem_ack = 1'b0;
    check("post_rst_empty", buf_empty, 1);
    ld_valid = 1'b1; ld_addr = 32'h504; #1;
    check("post_rst_ld_hit", ld_hit, 0);
    ld_valid = 1'b0;
    check("sb_leftover", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
